// File: rtl/d2l_pkg.sv
// Shared D2L definitions: link word width and the TX sequencer state encoding.
package d2l_pkg;

    localparam int unsigned D2L_DATA_W = 64;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLaunch = 2'd1,
        StWait   = 2'd2,
        StResult = 2'd3
    } d2l_state_e;

endpackage

// File: rtl/d2l_sync_fifo.sv
// Single-clock FIFO with combinational head read; count carries one extra bit so full != empty.
module d2l_sync_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_do_wr;
    logic              w_do_rd;

    assign full    = (r_count == COUNT_FULL);
    assign empty   = (r_count == '0);
    assign rd_data = r_mem[r_rd_ptr];

    // A write into a full FIFO is fine when the head leaves in the same cycle.
    assign w_do_wr = wr_en && (!full || rd_en);
    assign w_do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (!w_do_wr && w_do_rd) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/d2l_tx_sequencer.sv
// Feeds buffered words into D2L one at a time, waits for a fresh DONE rise (or timeout),
// returns the echoed word with a match flag and keeps saturating transfer/error counters.
module d2l_tx_sequencer
    import d2l_pkg::*;
#(
    parameter int unsigned DATA_W      = D2L_DATA_W,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              d2l_out_en,
    output logic [DATA_W-1:0] d2l_data_in,
    input  logic              d2l_done,
    input  logic [DATA_W-1:0] d2l_data_out,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_match,
    input  logic              m_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  tx_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              timeout_err
);

    localparam int unsigned     TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    d2l_state_e        r_state;
    logic              r_done_q;
    logic [TMR_W-1:0]  r_timer;
    logic [DATA_W-1:0] r_data_in;
    logic              r_out_en;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_match;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_timeout_err;

    logic              w_done_rise;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_head;

    assign w_push      = s_valid && !w_fifo_full;
    assign w_pop       = (r_state == StIdle) && !w_fifo_empty;
    // A DONE level left high by the previous word must not complete the next one.
    assign w_done_rise = d2l_done && !r_done_q;

    d2l_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (w_push),
        .wr_data (s_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_head),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= StIdle;
            r_done_q      <= 1'b0;
            r_timer       <= '0;
            r_data_in     <= '0;
            r_out_en      <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_match     <= 1'b0;
            r_tx_cnt      <= '0;
            r_err_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done_q <= d2l_done;
            r_out_en <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!w_fifo_empty) begin
                        r_data_in <= w_fifo_head;
                        r_out_en  <= 1'b1;
                        r_state   <= StLaunch;
                    end
                end
                StLaunch: begin
                    r_timer <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    if (w_done_rise) begin
                        r_m_data  <= d2l_data_out;
                        r_m_match <= (d2l_data_out == r_data_in);
                        r_m_valid <= 1'b1;
                        r_state   <= StResult;
                    end else if (r_timer == TMR_LAST) begin
                        r_m_data      <= '0;
                        r_m_match     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_m_valid     <= 1'b1;
                        r_state       <= StResult;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                StResult: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        if (r_tx_cnt != CNT_MAX) begin
                            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                        end
                        if (!r_m_match && (r_err_cnt != CNT_MAX)) begin
                            r_err_cnt <= r_err_cnt + CNT_W'(1);
                        end
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign s_ready     = !w_fifo_full;
    assign d2l_out_en  = r_out_en;
    assign d2l_data_in = r_data_in;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_match     = r_m_match;
    assign busy        = (r_state != StIdle) || !w_fifo_empty;
    assign tx_cnt      = r_tx_cnt;
    assign err_cnt     = r_err_cnt;
    assign timeout_err = r_timeout_err;

endmodule
